// File: rtl/adder_tree_pipe.sv
// rtl/adder_tree_pipe.sv - pipelined signed adder tree with optional saturation
//
// Sums N packed signed operands plus a bias (Beta) through a binary
// reduction tree with one register stage per tree level.
// L = ceil(log2(N+1)) levels, so latency is L enabled clock cycles.
//
// Parameters:
//   W    operand/result width (two's-complement)
//   N    number of data operands (1..31)
//   SAT  1 = saturating node adders, 0 = wrap-around node adders
//
// Ports:
//   clk          rising-edge clock
//   GlobalReset  asynchronous active-low reset, clears all pipeline state
//   en           pipeline advance enable; 0 holds every stage
//   in_valid     Operands/Beta carry a valid sample this cycle
//   Operands     packed operands, operand k at [W*k +: W]
//   Beta         bias, treated as the last leaf
//   Result       registered tree sum
//   out_valid    Result holds a valid sum
//   ovf          some node of this sample overflowed (meaningful with out_valid)

module adder_tree_pipe #(
  parameter int W   = 26,
  parameter int N   = 7,
  parameter int SAT = 1
) (
  input  logic           clk,
  input  logic           GlobalReset,
  input  logic           en,
  input  logic           in_valid,
  input  logic [W*N-1:0] Operands,
  input  logic [W-1:0]   Beta,
  output logic [W-1:0]   Result,
  output logic           out_valid,
  output logic           ovf
);

  localparam int LEAVES = N + 1;
  localparam int L      = $clog2(LEAVES);
  // The first level has the most pairs; later levels only have fewer.
  localparam int MAXP   = LEAVES / 2;

  logic [W-1:0] leaf   [0:N];
  logic [W-1:0] data_d [1:L][0:N];
  logic [W-1:0] data_q [1:L][0:N];
  logic [L-1:0] vld_d, vld_q;
  logic [L-1:0] ovf_d, ovf_q;

  // One tree node: W+1 bit sum, overflow when the two top bits differ.
  // Returns {overflow, node_value}.
  function automatic logic [W:0] add_node(input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0]   s;
    logic         of;
    logic [W-1:0] r;
    s  = {a[W-1], a} + {b[W-1], b};
    of = s[W] ^ s[W-1];
    r  = s[W-1:0];
    if ((SAT != 0) && of) begin
      // s[W] is the true sign of the unbounded sum.
      r = s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    return {of, r};
  endfunction

  always_comb begin
    for (int k = 0; k < N; k++) begin
      leaf[k] = Operands[W*k +: W];
    end
    leaf[N] = Beta;
  end

  // Next-state for every level. src holds the elements feeding the level
  // being built: the leaves for level 1, the previous level's registers
  // afterwards. Slots beyond a level's element count are held at zero.
  always_comb begin : p_tree
    logic [W-1:0] src [0:N];
    logic [W:0]   node;
    logic         lvl_ovf;
    logic         v_in;
    logic         o_in;
    int           cnt;
    int           pairs;

    vld_d = '0;
    ovf_d = '0;
    node  = '0;
    cnt   = LEAVES;
    v_in  = in_valid;
    o_in  = 1'b0;
    for (int j = 0; j <= N; j++) begin
      src[j] = leaf[j];
    end

    for (int l = 1; l <= L; l++) begin
      pairs   = cnt / 2;
      lvl_ovf = 1'b0;
      for (int j = 0; j <= N; j++) begin
        data_d[l][j] = '0;
      end
      for (int j = 0; j < MAXP; j++) begin
        if (j < pairs) begin
          node         = add_node(src[2*j], src[2*j+1]);
          data_d[l][j] = node[W-1:0];
          lvl_ovf      = lvl_ovf | node[W];
        end
      end
      // Odd element count: the unpaired last element passes through.
      if ((cnt % 2) != 0) begin
        data_d[l][pairs] = src[cnt-1];
      end
      vld_d[l-1] = v_in;
      ovf_d[l-1] = o_in | lvl_ovf;

      // Set up the inputs of the next level from this level's registers.
      for (int j = 0; j <= N; j++) begin
        src[j] = data_q[l][j];
      end
      v_in = vld_q[l-1];
      o_in = ovf_q[l-1];
      cnt  = cnt - pairs;
    end
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      for (int l = 1; l <= L; l++) begin
        for (int j = 0; j <= N; j++) begin
          data_q[l][j] <= '0;
        end
      end
      vld_q <= '0;
      ovf_q <= '0;
    end else if (en) begin
      data_q <= data_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
    end
  end

  assign Result    = data_q[L][0];
  assign out_valid = vld_q[L-1];
  assign ovf       = ovf_q[L-1];

endmodule

// File: tb/tb_adder_tree_pipe.sv
// tb/tb_adder_tree_pipe.sv - randomized and directed checks of adder_tree_pipe
module tb_adder_tree_pipe;

  localparam int W = 26;
  localparam longint MAXV = 33554431;
  localparam longint MINV = -33554432;
  localparam logic [W-1:0] PMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NMAX = {1'b1, {(W-1){1'b0}}};
  localparam int HMAX = 2048;

  typedef struct packed {
    logic         v;
    logic [W-1:0] r;
    logic         o;
  } exp_t;

  logic           clk;
  logic           GlobalReset;
  logic           en;
  logic           in_valid;
  logic [W*7-1:0] opv7;
  logic [W*5-1:0] opv5;
  logic [W-1:0]   opv1;
  logic [W-1:0]   beta7, beta5, beta1;
  logic [W-1:0]   res [0:3];
  logic           ov  [0:3];
  logic           of  [0:3];

  exp_t hist [0:3][0:HMAX-1];
  int   nhist;
  int   lat  [0:3];
  int   n_tests;
  int   n_fail;

  adder_tree_pipe #(.W(W), .N(7), .SAT(1)) u_n7_sat (
    .clk(clk), .GlobalReset(GlobalReset), .en(en), .in_valid(in_valid),
    .Operands(opv7), .Beta(beta7), .Result(res[0]), .out_valid(ov[0]), .ovf(of[0]));
  adder_tree_pipe #(.W(W), .N(7), .SAT(0)) u_n7_wrap (
    .clk(clk), .GlobalReset(GlobalReset), .en(en), .in_valid(in_valid),
    .Operands(opv7), .Beta(beta7), .Result(res[1]), .out_valid(ov[1]), .ovf(of[1]));
  adder_tree_pipe #(.W(W), .N(5), .SAT(1)) u_n5_sat (
    .clk(clk), .GlobalReset(GlobalReset), .en(en), .in_valid(in_valid),
    .Operands(opv5), .Beta(beta5), .Result(res[2]), .out_valid(ov[2]), .ovf(of[2]));
  adder_tree_pipe #(.W(W), .N(1), .SAT(1)) u_n1_sat (
    .clk(clk), .GlobalReset(GlobalReset), .en(en), .in_valid(in_valid),
    .Operands(opv1), .Beta(beta1), .Result(res[3]), .out_valid(ov[3]), .ovf(of[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    return {{(64-W){v[W-1]}}, v};
  endfunction

  function automatic logic [W-1:0] v26(input int x);
    return x[W-1:0];
  endfunction

  // Reference: reduce an array of integer leaves pairwise, level by level,
  // applying overflow/clamp/wrap to each pair sum with plain arithmetic.
  function automatic void tree(input longint lv_in [32], input int n_leaves,
                               input bit sat, output logic [W-1:0] r, output bit o);
    longint lv [32];
    longint s;
    int     cnt;
    int     p;
    lv  = lv_in;
    cnt = n_leaves;
    o   = 1'b0;
    while (cnt > 1) begin
      p = cnt / 2;
      for (int j = 0; j < p; j++) begin
        s = lv[2*j] + lv[2*j+1];
        if (s > MAXV || s < MINV) begin
          o = 1'b1;
          if (sat) s = (s > MAXV) ? MAXV : MINV;
          else     s = sx(s[W-1:0]);
        end
        lv[j] = s;
      end
      if ((cnt % 2) != 0) lv[p] = lv[cnt-1];
      cnt = cnt - p;
    end
    r = lv[0][W-1:0];
  endfunction

  task automatic record();
    longint       lv [32];
    logic [W-1:0] r;
    bit           o;
    if (nhist >= HMAX) begin
      check_eq("hist_overflow", 32'(nhist), 32'(HMAX - 1));
      return;
    end
    for (int k = 0; k < 32; k++) lv[k] = 0;
    for (int k = 0; k < 7; k++) lv[k] = sx(opv7[W*k +: W]);
    lv[7] = sx(beta7);
    tree(lv, 8, 1'b1, r, o);
    hist[0][nhist] = '{v: in_valid, r: r, o: o};
    tree(lv, 8, 1'b0, r, o);
    hist[1][nhist] = '{v: in_valid, r: r, o: o};
    for (int k = 0; k < 32; k++) lv[k] = 0;
    for (int k = 0; k < 5; k++) lv[k] = sx(opv5[W*k +: W]);
    lv[5] = sx(beta5);
    tree(lv, 6, 1'b1, r, o);
    hist[2][nhist] = '{v: in_valid, r: r, o: o};
    for (int k = 0; k < 32; k++) lv[k] = 0;
    lv[0] = sx(opv1);
    lv[1] = sx(beta1);
    tree(lv, 2, 1'b1, r, o);
    hist[3][nhist] = '{v: in_valid, r: r, o: o};
    nhist++;
  endtask

  // Output of each DUT is the sample accepted lat[d] enabled edges ago;
  // before that many edges since reset the outputs are still cleared.
  task automatic check_outputs();
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      if (nhist < lat[d]) begin
        check_eq($sformatf("d%0d_rst_valid", d), 32'(ov[d]), 32'd0);
        check_eq($sformatf("d%0d_rst_result", d), 32'(res[d]), 32'd0);
        check_eq($sformatf("d%0d_rst_ovf", d), 32'(of[d]), 32'd0);
      end else begin
        e = hist[d][nhist - lat[d]];
        check_eq($sformatf("d%0d_valid@%0d", d, nhist), 32'(ov[d]), 32'(e.v));
        if (e.v) begin
          check_eq($sformatf("d%0d_result@%0d", d, nhist), 32'(res[d]), 32'(e.r));
          check_eq($sformatf("d%0d_ovf@%0d", d, nhist), 32'(of[d]), 32'(e.o));
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (GlobalReset && en) record();
    #1;
    check_outputs();
  endtask

  function automatic logic [W-1:0] rnd_val();
    int unsigned t;
    int          s;
    t = $urandom();
    s = int'($urandom_range(0, 2000)) - 1000;
    case ($urandom_range(0, 3))
      0:       return t[W-1:0];
      1:       return s[W-1:0];
      2:       return t[0] ? PMAX : NMAX;
      default: return t[1] ? PMAX - v26(s + 1000) : NMAX + v26(s + 1000);
    endcase
  endfunction

  task automatic randomize_inputs();
    for (int k = 0; k < 7; k++) opv7[W*k +: W] = rnd_val();
    for (int k = 0; k < 5; k++) opv5[W*k +: W] = rnd_val();
    opv1  = rnd_val();
    beta7 = rnd_val();
    beta5 = rnd_val();
    beta1 = rnd_val();
  endtask

  task automatic set_all7(input logic [W-1:0] v);
    for (int k = 0; k < 7; k++) opv7[W*k +: W] = v;
    beta7 = v;
  endtask

  initial begin
    int first;
    n_tests = 0;
    n_fail  = 0;
    nhist   = 0;
    lat     = '{3, 3, 3, 1};
    GlobalReset = 1'b0;
    en       = 1'b0;
    in_valid = 1'b0;
    opv7 = '0; opv5 = '0; opv1 = '0;
    beta7 = '0; beta5 = '0; beta1 = '0;

    // Reset state, then release between edges.
    #12;
    check_outputs();
    GlobalReset = 1'b1;
    en = 1'b1;

    // All ones, single sample: 8 after three cycles, valid for one cycle.
    set_all7(v26(1));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check_eq("ones_result", 32'(res[0]), 32'd8);
    check_eq("ones_valid", 32'(ov[0]), 32'd1);
    check_eq("ones_ovf", 32'(of[0]), 32'd0);
    step();
    check_eq("ones_valid_drop", 32'(ov[0]), 32'd0);

    // Every leaf at positive full scale: clamp vs wrap.
    set_all7(PMAX);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    check_eq("sat_result", 32'(res[0]), 32'(PMAX));
    check_eq("sat_ovf", 32'(of[0]), 32'd1);
    check_eq("wrap_result", 32'h3FFFFF8, 32'(res[1]));
    check_eq("wrap_ovf", 32'(of[1]), 32'd1);

    // Operand k = k+1, Beta = -28, then back-to-back Beta = 0..3.
    for (int k = 0; k < 7; k++) opv7[W*k +: W] = v26(k + 1);
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 5);
      beta7    = (i == 0) ? v26(-28) : v26(i - 1);
      step();
      if (i == 2) begin
        check_eq("neg_bias_result", 32'(res[0]), 32'd0);
        check_eq("neg_bias_ovf", 32'(of[0]), 32'd0);
      end
      if (i >= 3 && i <= 6) begin
        check_eq($sformatf("b2b_result_%0d", i - 3), 32'(res[0]), 32'(28 + i - 3));
        check_eq($sformatf("b2b_valid_%0d", i - 3), 32'(ov[0]), 32'd1);
      end
    end

    // Smaller trees: N=5 (three levels) and N=1 (one level).
    opv5[W*0 +: W] = v26(100);
    opv5[W*1 +: W] = v26(-200);
    opv5[W*2 +: W] = v26(300);
    opv5[W*3 +: W] = v26(-400);
    opv5[W*4 +: W] = v26(500);
    beta5 = v26(7);
    opv1  = v26(-5);
    beta1 = v26(2);
    in_valid = 1'b1;
    step();
    check_eq("n1_result", 32'(res[3]), 32'(v26(-3)));
    check_eq("n1_valid", 32'(ov[3]), 32'd1);
    in_valid = 1'b0;
    step();
    step();
    check_eq("n5_result", 32'(res[2]), 32'd307);
    check_eq("n5_valid", 32'(ov[2]), 32'd1);
    step();
    step();

    // Stall: en low for two cycles after the first edge.
    first = -1;
    randomize_inputs();
    for (int k = 1; k <= 10; k++) begin
      in_valid = (k == 1);
      en       = !(k == 2 || k == 3);
      step();
      if (first < 0 && ov[0]) first = k;
    end
    check_eq("stall_latency", 32'(first), 32'd5);
    en = 1'b1;

    // Reset pulse between edges with two samples in flight.
    in_valid = 1'b1;
    randomize_inputs();
    step();
    randomize_inputs();
    step();
    in_valid = 1'b0;
    #2;
    GlobalReset = 1'b0;
    #1;
    nhist = 0;
    for (int d = 0; d < 4; d++) begin
      check_eq($sformatf("d%0d_midrst_result", d), 32'(res[d]), 32'd0);
      check_eq($sformatf("d%0d_midrst_valid", d), 32'(ov[d]), 32'd0);
      check_eq($sformatf("d%0d_midrst_ovf", d), 32'(of[d]), 32'd0);
    end
    #2;
    GlobalReset = 1'b1;
    for (int k = 0; k < 5; k++) step();

    // Randomized traffic with random stalls.
    for (int c = 0; c < 600; c++) begin
      randomize_inputs();
      in_valid = ($urandom_range(0, 9) < 6);
      en       = ($urandom_range(0, 3) != 0);
      step();
    end
    en = 1'b1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_tree_pipe.md
ADDER_TREE_PIPE -- requirements
Module: adder_tree_pipe

Interface
REQ-001 SHALL have parameter W, default 26, meaning operand/result width in two's-complement signed bits.
REQ-002 SHALL have parameter N, default 7, meaning number of data operands, legal range 1..31.
REQ-003 SHALL have parameter SAT, default 1, meaning 1 = saturating adders, 0 = wrap-around adders.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port GlobalReset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  pipeline advance enable; 0 = whole pipeline holds.
REQ-007 SHALL have port in_valid  input  1  operands and bias valid this cycle.
REQ-008 SHALL have port Operands  input  W*N  packed operands; operand k at bits [W*k+W-1:W*k].
REQ-009 SHALL have port Beta  input  W  bias, summed as leaf N.
REQ-010 SHALL have port Result  output  W  registered sum of all operands plus Beta.
REQ-011 SHALL have port out_valid  output  1  Result holds a valid sum.
REQ-012 SHALL have port ovf  output  1  at least one tree node overflowed for this sample.

Function
REQ-013 SHALL form N+1 leaves: leaf k = operand k for k<N, leaf N = Beta.
REQ-014 SHALL reduce leaves in L = ceil(log2(N+1)) levels, one register stage per level; L=0 not possible since N+1>=2.
REQ-015 SHALL at each level compute node j = elem[2j] + elem[2j+1]; when the element count is odd, the last element SHALL pass to the next level registered, unchanged, with no overflow.
REQ-016 SHALL compute each node sum at W+1 bits; overflow = true sum outside [-2^(W-1), 2^(W-1)-1].
REQ-017 SHALL, with SAT=1, clamp an overflowing node to 2^(W-1)-1 (positive) or -2^(W-1) (negative).
REQ-018 SHALL, with SAT=0, keep the low W bits of every node (wrap modulo 2^W).
REQ-019 SHALL carry a per-sample overflow bit through the pipeline, ORed with every node overflow of that sample; ovf is that bit at the output.
REQ-020 SHALL carry in_valid through an L-deep valid shift chain aligned with the data; out_valid is its last stage.
REQ-021 SHALL, with en=1, advance every stage each cycle: latency exactly L cycles from sample on inputs to Result/out_valid/ovf.
REQ-022 SHALL sustain throughput of one sample per cycle with back-to-back in_valid=1.
REQ-023 SHALL, with en=0, hold every data, valid and overflow register unchanged, and ignore inputs that cycle.
REQ-024 SHALL register data regardless of in_valid; Result content with out_valid=0 is don't-care except after reset.
REQ-025 SHALL keep ovf meaningful only when out_valid=1.

Reset
REQ-026 SHALL, on GlobalReset=0, asynchronously clear all pipeline data, valid and overflow registers to 0 (Result=0, out_valid=0, ovf=0), independent of clk and en.
REQ-027 SHALL discard all in-flight samples on reset mid-operation; first out_valid after release occurs L enabled cycles after the first post-reset valid input.
REQ-028 SHALL begin accepting inputs on the first rising clk edge with GlobalReset=1.

Verification
REQ-029 SHALL pass: W=26,N=7,SAT=1, all operands=1, Beta=1, in_valid=1 one cycle -> 3 cycles later Result=8, out_valid=1 for one cycle, ovf=0.
REQ-030 SHALL pass: W=26,N=7, all operands and Beta=0x1FFFFFF -> SAT=1: Result=0x1FFFFFF, ovf=1; SAT=0: Result=0x3FFFFF8, ovf=1.
REQ-031 SHALL pass: operands k = k+1, Beta=-28 (0x3FFFFE4) -> Result=0, ovf=0; samples on 4 consecutive cycles with Beta=0,1,2,3 -> Results 28,29,30,31 on 4 consecutive cycles.
REQ-032 SHALL pass: sample issued, en=0 for 2 cycles after first edge -> out_valid first asserted 5 cycles after issue, Result unchanged during stall.
REQ-033 SHALL pass: GlobalReset pulsed low between clock edges while 2 samples in flight -> Result=0, out_valid=0, ovf=0 immediately; neither sample emerges.
REQ-034 SHALL pass: N=5 (L=3), operands=100,-200,300,-400,500, Beta=7 -> Result=307 after 3 cycles; N=1 (L=1), operand=-5, Beta=2 -> Result=-3 after 1 cycle.
